// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences operand loads, ALU settle, and two-word result output
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [63:0] alu_result,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_OUT_LO, S_OUT_HI, S_HALTED
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] z_q, z_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        op_legal;
    logic        wide_op;

    always_comb begin
        op_legal = ((op >= 5'b00011) && (op <= 5'b01010)) ||
                   ((op >= 5'b01110) && (op <= 5'b10001)) ||
                   (op == OP_NOP);
        wide_op  = (op_q == OP_MUL) || (op_q == OP_DIV);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_HALT) begin
                        state_d = S_HALTED;
                    end else if (op_legal) begin
                        op_d = op;
                        if (op == OP_NOP) begin
                            z_d     = 64'h0;
                            state_d = S_OUT_LO;
                        end else begin
                            state_d = S_LOAD_A;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_A: begin
                if (in_valid) begin
                    a_d = in_data;
                    // Unary ops have no second operand; B is forced to zero for the ALU.
                    if ((op_q == OP_NEG) || (op_q == OP_NOT)) begin
                        b_d     = 32'h0;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_LOAD_B;
                    end
                end
            end
            S_LOAD_B: begin
                if (in_valid) begin
                    b_d     = in_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == SETTLE_LAST) begin
                    z_d     = alu_result;
                    cnt_d   = 4'h0;
                    state_d = S_OUT_LO;
                end else begin
                    cnt_d = cnt_q + 4'h1;
                end
            end
            S_OUT_LO: begin
                if (out_ready) begin
                    if (wide_op) begin
                        state_d = S_OUT_HI;
                    end else begin
                        state_d = S_IDLE;
                        op_d    = OP_NOP;
                    end
                end
            end
            S_OUT_HI: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    op_d    = OP_NOP;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
                op_d    = OP_NOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            z_q     <= 64'h0;
            cnt_q   <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
        out_valid = (state_q == S_OUT_LO) || (state_q == S_OUT_HI);
        out_last  = ((state_q == S_OUT_LO) && !wide_op) || (state_q == S_OUT_HI);
        out_data  = 32'h0;
        if (state_q == S_OUT_LO) begin
            out_data = z_q[31:0];
        end else if (state_q == S_OUT_HI) begin
            out_data = z_q[63:32];
        end
        busy     = (state_q != S_IDLE);
        halted   = (state_q == S_HALTED);
        err      = err_q;
        alu_a    = a_q;
        alu_b    = b_q;
        alu_ctrl = op_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized and directed bench with a behavioural ALU/result model
module tb_alu_op_sequencer;

    localparam int SETTLE = 1;
    localparam logic [4:0] NOP = 5'b11001;

    logic        clk;
    logic        clr;
    logic        start;
    logic [4:0]  op;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        halted;
    logic        err;

    int total  = 0;
    int passed = 0;
    logic [31:0] got_data[$];
    logic        got_last[$];

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .halted(halted), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU: drives the DUT's ALU input and also serves as the result model.
    function automatic logic [63:0] alu_fn(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            5'b00011: return 64'(a) + 64'(b);
            5'b00100: return {32'hA5A5A5A5, a - b};
            5'b00101: return {32'h0, a & b};
            5'b00110: return {32'h0, a | b};
            5'b00111: return {32'h0, a ^ b};
            5'b01000: return 64'(a) << b[4:0];
            5'b01001: return {32'h0, a >> b[4:0]};
            5'b01010: return {32'h0, 31'h0, a < b};
            5'b01110: return 64'(a) * 64'(b);
            5'b01111: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
            5'b10000: return 64'h0 - 64'(a);
            5'b10001: return ~64'(a);
            default:  return 64'h0;
        endcase
    endfunction

    function automatic bit is_unary(input logic [4:0] o);
        return (o == 5'b10000) || (o == 5'b10001);
    endfunction

    function automatic bit is_wide(input logic [4:0] o);
        return (o == 5'b01110) || (o == 5'b01111);
    endfunction

    always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int vpct, input int rpct, output int lat);
        int   n_sent;
        bit   done;
        bit   held;
        logic [31:0] held_data;
        logic held_last;
        got_data.delete();
        got_last.delete();
        lat = -1; n_sent = 0; done = 0; held = 0; held_data = 0; held_last = 0;
        @(negedge clk);
        start = 1'b1; op = o; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            op    = 5'($urandom);
            if (out_valid && lat < 0) lat = cyc;
            total++;
            if (!out_valid && out_data !== 32'h0) $display("FAIL idle_out_data got=%h exp=00000000", out_data);
            else passed++;
            total++;
            if (busy !== 1'b1) $display("FAIL busy_during_op got=%b exp=1", busy);
            else passed++;
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last)
                    $display("FAIL hold_stable got=%b/%h/%b exp=1/%h/%b", out_valid, out_data, out_last, held_data, held_last);
                else passed++;
            end
            in_valid  = ($urandom_range(99) < vpct);
            in_data   = in_valid ? ((n_sent == 0) ? a : b) : $urandom;
            out_ready = ($urandom_range(99) < rpct);
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (in_valid && in_ready) n_sent++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last) done = 1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (!done) $display("FAIL op_timeout got=no_last exp=last_beat op=%b", o);
        else passed++;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || alu_ctrl !== NOP)
            $display("FAIL post_op_idle got=%b/%b/%b exp=0/0/%b", busy, out_valid, alu_ctrl, NOP);
        else passed++;
    endtask

    task automatic test_reset;
        total++;
        if (in_ready !== 0 || out_valid !== 0 || out_last !== 0 || busy !== 0 || halted !== 0 || err !== 0)
            $display("FAIL reset_flags got=%b%b%b%b%b%b exp=000000", in_ready, out_valid, out_last, busy, halted, err);
        else passed++;
        total++;
        if (out_data !== 0 || alu_a !== 0 || alu_b !== 0 || alu_ctrl !== NOP)
            $display("FAIL reset_data got=%h/%h/%h/%b exp=0/0/0/%b", out_data, alu_a, alu_b, alu_ctrl, NOP);
        else passed++;
    endtask

    task automatic test_add;
        int lat;
        run_op(5'b00011, 32'd5, 32'd7, 100, 100, lat);
        total++;
        if (lat !== 3 + SETTLE) $display("FAIL add_latency got=%0d exp=%0d", lat, 3 + SETTLE);
        else passed++;
        total++;
        if (got_data.size() != 1 || got_data[0] !== 32'h0000000C || got_last[0] !== 1'b1)
            $display("FAIL add_beat got=n%0d/%h exp=n1/0000000C", got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx);
        else passed++;
        total++;
        if (alu_a !== 32'd5 || alu_b !== 32'd7) $display("FAIL add_operands got=%h/%h exp=5/7", alu_a, alu_b);
        else passed++;
    endtask

    task automatic test_mul;
        int lat;
        run_op(5'b01110, 32'h00010000, 32'h00010000, 100, 100, lat);
        total++;
        if (got_data.size() != 2) $display("FAIL mul_count got=%0d exp=2", got_data.size());
        else if (got_data[0] !== 32'h0 || got_last[0] !== 1'b0 || got_data[1] !== 32'h1 || got_last[1] !== 1'b1)
            $display("FAIL mul_beats got=%h/%b,%h/%b exp=00000000/0,00000001/1", got_data[0], got_last[0], got_data[1], got_last[1]);
        else passed++;
    endtask

    task automatic test_neg;
        int lat;
        run_op(5'b10000, 32'd1, 32'hDEADBEEF, 100, 100, lat);
        total++;
        if (lat !== 2 + SETTLE) $display("FAIL neg_latency got=%0d exp=%0d", lat, 2 + SETTLE);
        else passed++;
        total++;
        if (alu_b !== 32'h0) $display("FAIL neg_alu_b got=%h exp=00000000", alu_b);
        else passed++;
        total++;
        if (got_data.size() != 1 || got_data[0] !== 32'hFFFFFFFF || got_last[0] !== 1'b1)
            $display("FAIL neg_beat got=n%0d exp=n1/FFFFFFFF", got_data.size());
        else passed++;
    endtask

    task automatic test_nop;
        int lat;
        run_op(NOP, 32'h0, 32'h0, 100, 100, lat);
        total++;
        if (lat !== 1 || got_data.size() != 1 || got_data[0] !== 32'h0 || got_last[0] !== 1'b1)
            $display("FAIL nop got=lat%0d/n%0d exp=lat1/n1/00000000/1", lat, got_data.size());
        else passed++;
    endtask

    task automatic test_backpressure;
        int w;
        @(negedge clk); start = 1'b1; op = 5'b00011;
        @(posedge clk);
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 32'd100;
        @(posedge clk);
        @(negedge clk); in_data = 32'd23;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(posedge clk); @(negedge clk); w++;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'd123 || out_last !== 1'b1)
                $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/0000007B/1", i, out_valid, out_data, out_last);
            else passed++;
            if (i < 2) begin @(posedge clk); @(negedge clk); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_single_beat got=%b/%b exp=0/0", out_valid, busy);
        else passed++;
    endtask

    task automatic test_start_while_busy;
        @(negedge clk); start = 1'b1; op = 5'b00011;
        @(posedge clk);
        @(negedge clk); op = 5'b01110; in_valid = 1'b1; in_data = 32'd10;
        @(posedge clk);
        @(negedge clk); in_data = 32'd20;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        total++;
        if (alu_ctrl !== 5'b00011) $display("FAIL busy_alu_ctrl got=%b exp=00011", alu_ctrl);
        else passed++;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd30 || out_last !== 1'b1)
            $display("FAIL busy_ignore got=%b/%h/%b exp=1/0000001E/1", out_valid, out_data, out_last);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); out_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL busy_done got=%b/%b exp=0/0", busy, out_valid);
        else passed++;
    endtask

    task automatic test_illegal;
        logic [4:0] bad[8];
        bad = '{5'b00000, 5'b00010, 5'b01011, 5'b01101, 5'b10010, 5'b11000, 5'b11011, 5'b11111};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); start = 1'b1; op = bad[i];
            @(posedge clk);
            @(negedge clk); start = 1'b0;
            total++;
            if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL illegal_err op=%b got=%b/%b/%b exp=1/0/0", bad[i], err, busy, in_ready);
            else passed++;
            @(posedge clk);
            @(negedge clk);
            total++;
            if (err !== 1'b0 || busy !== 1'b0) $display("FAIL illegal_pulse op=%b got=%b/%b exp=0/0", bad[i], err, busy);
            else passed++;
        end
    endtask

    task automatic test_random;
        logic [4:0] legal[13];
        logic [4:0] o;
        logic [31:0] a, b;
        logic [63:0] z;
        int lat;
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17, 5'd25};
        for (int n = 0; n < 40; n++) begin
            o = legal[$urandom_range(12)];
            a = $urandom;
            b = ($urandom_range(9) == 0) ? 32'h0 : $urandom;
            run_op(o, a, b, 30 + $urandom_range(70), 30 + $urandom_range(70), lat);
            z = (o == NOP) ? 64'h0 : alu_fn(o, a, is_unary(o) ? 32'h0 : b);
            total++;
            if (got_data.size() != (is_wide(o) ? 2 : 1))
                $display("FAIL rand_count op=%b got=%0d exp=%0d", o, got_data.size(), is_wide(o) ? 2 : 1);
            else if (got_data[0] !== z[31:0] || got_last[0] !== !is_wide(o))
                $display("FAIL rand_lo op=%b got=%h/%b exp=%h/%b", o, got_data[0], got_last[0], z[31:0], !is_wide(o));
            else if (is_wide(o) && (got_data[1] !== z[63:32] || got_last[1] !== 1'b1))
                $display("FAIL rand_hi op=%b got=%h/%b exp=%h/1", o, got_data[1], got_last[1], z[63:32]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        bit saw;
        @(negedge clk); start = 1'b1; op = 5'b00011;
        @(posedge clk);
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 32'h1234;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b1; in_data = 32'h99;
        #2 clr = 1'b0;
        #1;
        total++;
        if (busy !== 0 || in_ready !== 0 || out_valid !== 0 || alu_a !== 0 || alu_ctrl !== NOP)
            $display("FAIL async_reset got=%b/%b/%b/%h/%b exp=0/0/0/0/%b", busy, in_ready, out_valid, alu_a, alu_ctrl, NOP);
        else passed++;
        @(negedge clk); clr = 1'b1; out_ready = 1'b1;
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid || busy) saw = 1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (saw !== 1'b0) $display("FAIL reset_abandon got=activity exp=none");
        else passed++;
    endtask

    task automatic test_halt;
        @(negedge clk); start = 1'b1; op = 5'b11010;
        @(posedge clk);
        @(negedge clk); op = 5'b00011; in_valid = 1'b1; out_ready = 1'b1;
        total++;
        if (halted !== 1 || busy !== 1 || in_ready !== 0 || out_valid !== 0 || err !== 0)
            $display("FAIL halt_state got=%b/%b/%b/%b/%b exp=1/1/0/0/0", halted, busy, in_ready, out_valid, err);
        else passed++;
        for (int i = 0; i < 5; i++) begin @(posedge clk); @(negedge clk); end
        total++;
        if (halted !== 1 || in_ready !== 0 || out_valid !== 0) $display("FAIL halt_sticky got=%b/%b/%b exp=1/0/0", halted, in_ready, out_valid);
        else passed++;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2 clr = 1'b0;
        #1;
        total++;
        if (halted !== 0 || busy !== 0) $display("FAIL halt_clear got=%b/%b exp=0/0", halted, busy);
        else passed++;
        @(negedge clk); clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; op = 5'b0; in_data = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        test_reset;
        @(negedge clk); clr = 1'b1;
        test_add;
        test_mul;
        test_neg;
        test_nop;
        test_backpressure;
        test_start_while_busy;
        test_illegal;
        test_random;
        test_reset_mid;
        test_halt;
        test_add;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
